// File: rtl/fpu_fp64_addctl.sv
// Sequencing controller for an external combinational FP64 adder. It registers operands,
// resolves NaN/Inf cases locally, and returns tagged results through a ready/valid handshake.
`timescale 1ns/1ps
module fpu_fp64_addctl #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [63:0] req_srca,
  input  logic [63:0] req_srcb,
  input  logic [3:0]  req_tag,
  output logic        add_enable,
  output logic        add_doSub,
  output logic [63:0] add_srca,
  output logic [63:0] add_srcb,
  input  logic [63:0] add_dst,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic [3:0]  rsp_tag,
  output logic [2:0]  rsp_flags,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, BYPASS = 2'd2, RESP = 2'd3} state_t;

  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  function automatic logic is_special(input logic [63:0] x);
    return x[62:52] == 11'h7FF;
  endfunction

  function automatic logic is_nan(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
  endfunction

  function automatic logic is_inf(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] == 52'd0);
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] srca_q, srcb_q;
  logic        dosub_q;
  logic [3:0]  tag_q;
  logic [63:0] rsp_data_q;
  logic [3:0]  rsp_tag_q;
  logic [2:0]  rsp_flags_q;
  logic        rdy_en_q;
  logic        accept_s;
  logic        route_byp_s;
  logic [63:0] byp_data_s;
  logic [2:0]  byp_flags_s;
  logic        b_sign_eff_s;

  assign accept_s    = req_valid && req_ready;
  assign route_byp_s = is_special(req_srca) || is_special(req_srcb);

  assign add_srca  = srca_q;
  assign add_srcb  = srcb_q;
  assign add_doSub = dosub_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_flags = rsp_flags_q;

  // State register and settle counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept_s) begin
          if (route_byp_s) begin
            state_d = BYPASS;
          end else begin
            state_d = ISSUE;
            cnt_d   = 4'(SETTLE_CYC - 1);
          end
        end else if (state_q == RESP && rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      ISSUE: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      BYPASS:  state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; ready is held off until the first edge after reset release
  always_comb begin
    add_enable = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    req_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        busy      = 1'b0;
        req_ready = rdy_en_q;
      end
      ISSUE:  add_enable = 1'b1;
      BYPASS: add_enable = 1'b0;
      RESP: begin
        rsp_valid = 1'b1;
        req_ready = rdy_en_q && rsp_ready;
      end
      default: busy = 1'b1;
    endcase
  end

  // Special-operand result using effective signs after the reverse-sub swap
  always_comb begin
    b_sign_eff_s = srcb_q[63] ^ dosub_q;
    if (is_nan(srca_q) || is_nan(srcb_q) ||
        (is_inf(srca_q) && is_inf(srcb_q) && (srca_q[63] != b_sign_eff_s))) begin
      byp_data_s  = QNAN;
      byp_flags_s = 3'b100;
    end else if (is_inf(srca_q)) begin
      byp_data_s  = {srca_q[63], 11'h7FF, 52'd0};
      byp_flags_s = 3'b000;
    end else begin
      byp_data_s  = {b_sign_eff_s, 11'h7FF, 52'd0};
      byp_flags_s = 3'b000;
    end
  end

  // Operand capture on accept, result capture on leaving ISSUE/BYPASS
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      srca_q      <= 64'd0;
      srcb_q      <= 64'd0;
      dosub_q     <= 1'b0;
      tag_q       <= 4'd0;
      rsp_data_q  <= 64'd0;
      rsp_tag_q   <= 4'd0;
      rsp_flags_q <= 3'd0;
    end else begin
      if (accept_s) begin
        srca_q  <= (req_op == 2'b10) ? req_srcb : req_srca;
        srcb_q  <= (req_op == 2'b10) ? req_srca : req_srcb;
        dosub_q <= (req_op == 2'b01) || (req_op == 2'b10);
        tag_q   <= req_tag;
      end
      if (state_q == ISSUE && cnt_q == 4'd0) begin
        rsp_data_q  <= add_dst;
        rsp_tag_q   <= tag_q;
        rsp_flags_q <= {1'b0, add_dst[62:52] == 11'h7FF, add_dst[62:0] == 63'd0};
      end else if (state_q == BYPASS) begin
        rsp_data_q  <= byp_data_s;
        rsp_tag_q   <= tag_q;
        rsp_flags_q <= byp_flags_s;
      end
    end
  end

endmodule

// File: tb/tb_fpu_fp64_addctl.sv
// Scoreboard bench for fpu_fp64_addctl: directed vectors push expected results, a monitor
// compares each handshaken response and its latency.
`timescale 1ns/1ps
module tb_fpu_fp64_addctl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [63:0] req_srca, req_srcb;
  logic [3:0]  req_tag;
  logic        add_enable, add_doSub;
  logic [63:0] add_srca, add_srcb, add_dst;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic [2:0]  rsp_flags;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int en_hits = 0;
  bit watch_en = 1'b0;
  bit prev_v = 1'b0;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  tag;
    logic [2:0]  flags;
    int          acc;
    int          lat;
  } exp_t;
  exp_t sbq[$];

  localparam logic [63:0] ONE  = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] TWO  = 64'h4000_0000_0000_0000;
  localparam logic [63:0] THR  = 64'h4008_0000_0000_0000;
  localparam logic [63:0] PINF = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] NINF = 64'hFFF0_0000_0000_0000;
  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] FMAX = 64'h7FEF_FFFF_FFFF_FFFF;

  fpu_fp64_addctl #(.SETTLE_CYC(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_srca(req_srca), .req_srcb(req_srcb), .req_tag(req_tag),
    .add_enable(add_enable), .add_doSub(add_doSub),
    .add_srca(add_srca), .add_srcb(add_srcb), .add_dst(add_dst),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_flags(rsp_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [63:0] fadd(input logic [63:0] a, input logic [63:0] b, input logic s);
    real ra, rb;
    ra = $bitstoreal(a);
    rb = $bitstoreal(b);
    return $realtobits(s ? (ra - rb) : (ra + rb));
  endfunction

  // Behavioural stand-in for the downstream adder
  always_comb add_dst = fadd(add_srca, add_srcb, add_doSub);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (watch_en && add_enable) en_hits++;
    if (rsp_valid && !prev_v) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got tag %h data %h, required no response", rsp_tag, rsp_data);
      end else begin
        chk("latency", 64'(cyc - sbq[0].acc), 64'(sbq[0].lat));
      end
    end
    if (rsp_valid && rsp_ready && sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("rsp_data", rsp_data, e.data);
      chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
      chk("rsp_flags", 64'(rsp_flags), 64'(e.flags));
    end
    prev_v = rsp_valid;
  end

  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op,
                      input logic [3:0] tag, input logic [63:0] ed, input logic [2:0] ef,
                      input int lat, input bit exp_rsp);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_srca = a; req_srcb = b; req_op = op; req_tag = tag;
    #1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got req_ready 0 for tag %h, required 1 within 50 cycles", tag);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (exp_rsp) begin
      e = '{ed, tag, ef, cyc, lat};
      sbq.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    int n;
    reset_n = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_op = 2'b00; req_srca = 64'd0; req_srcb = 64'd0; req_tag = 4'd0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_add_enable", 64'(add_enable), 64'd0);
    chk("rst_add_srca", add_srca, 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_rsp_tag_flags", 64'({rsp_tag, rsp_flags}), 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);

    send(ONE, TWO, 2'b00, 4'd5, THR, 3'b000, 2, 1'b1);
    send(THR, THR, 2'b01, 4'd1, 64'd0, 3'b001, 2, 1'b1);
    send(ONE, THR, 2'b10, 4'd2, TWO, 3'b000, 2, 1'b1);
    chk("rev_add_srca", add_srca, THR);
    chk("rev_add_srcb", add_srcb, ONE);
    chk("rev_add_doSub", 64'(add_doSub), 64'd1);
    chk("issue_add_enable", 64'(add_enable), 64'd1);
    drain();

    watch_en = 1'b1;
    send(PINF, NINF, 2'b00, 4'd3, QNAN, 3'b100, 1, 1'b1);
    send(ONE, PINF, 2'b01, 4'd6, NINF, 3'b000, 1, 1'b1);
    send(PINF, PINF, 2'b01, 4'd7, QNAN, 3'b100, 1, 1'b1);
    send(ONE, 64'h7FF0_0000_0000_0001, 2'b00, 4'd8, QNAN, 3'b100, 1, 1'b1);
    send(PINF, ONE, 2'b10, 4'd9, NINF, 3'b000, 1, 1'b1);
    drain();
    watch_en = 1'b0;
    chk("bypass_add_enable_hits", 64'(en_hits), 64'd0);

    send(ONE, ONE, 2'b11, 4'd4, TWO, 3'b000, 2, 1'b1);
    send(FMAX, FMAX, 2'b00, 4'd10, PINF, 3'b010, 2, 1'b1);
    drain();

    // Backpressure with an ignored request held on the inputs
    rsp_ready = 1'b0;
    send(ONE, TWO, 2'b00, 4'd7, THR, 3'b000, 2, 1'b1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_srca = 64'h4010_0000_0000_0000; req_srcb = ONE; req_op = 2'b10; req_tag = 4'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rsp_data", rsp_data, THR);
      chk("bp_rsp_tag", 64'(rsp_tag), 64'd7);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_add_srca", add_srca, ONE);
    end
    @(negedge clk);
    req_srca = TWO; req_srcb = ONE; req_op = 2'b01; req_tag = 4'd8;
    rsp_ready = 1'b1;
    #1;
    chk("b2b_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    sbq.push_back('{ONE, 4'd8, 3'b000, cyc, 2});
    chk("b2b_add_srca", add_srca, TWO);
    drain();

    // Reset in the middle of ISSUE
    send(ONE, TWO, 2'b00, 4'd12, THR, 3'b000, 2, 1'b0);
    chk("mid_add_enable", 64'(add_enable), 64'd1);
    chk("mid_busy", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_add_enable", 64'(add_enable), 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_add_srca", add_srca, 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);

    send(TWO, ONE, 2'b11, 4'd11, THR, 3'b000, 2, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_fp64_addctl.md
FPU_FP64_ADDCTL -- requirements
Module: fpu_fp64_addctl

Interface
REQ-001 SHALL provide parameter SETTLE_CYC, default 2, meaning the number of cycles the downstream FP64 adder is held enabled before its result is sampled; legal range 1..15.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  request accepted this cycle when high with req_valid.
REQ-007 req_op  in  2  00 add; 01 sub (a-b); 10 reverse sub (b-a); 11 add.
REQ-008 req_srca / req_srcb  in  64 each  IEEE-754 binary64 operands.
REQ-009 req_tag  in  4  opaque tag, returned with the result.
REQ-010 add_enable  out  1  enable to the FP64 adder.
REQ-011 add_doSub  out  1  subtract select to the adder.
REQ-012 add_srca / add_srcb  out  64 each  registered adder operands.
REQ-013 add_dst  in  64  adder result, combinational from add_srca/add_srcb/add_doSub.
REQ-014 rsp_valid  out  1  result present.
REQ-015 rsp_ready  in  1  consumer accepts the result.
REQ-016 rsp_data  out  64  result.
REQ-017 rsp_tag  out  4  tag of the result.
REQ-018 rsp_flags  out  3  bit0 zero, bit1 overflow-to-inf, bit2 invalid/NaN.
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, ISSUE, BYPASS, RESP.
REQ-021 req_ready SHALL be high in IDLE, and in RESP during the cycle rsp_valid&&rsp_ready; it SHALL be low otherwise.
REQ-022 On accept, operands, op and tag SHALL be registered.
  - op 10: register srca<=req_srcb, srcb<=req_srca, doSub=1.
  - op 01: register doSub=1.
  - op 00/11: register doSub=0.
REQ-023 Special detect on accept: an operand with exponent field 0x7FF SHALL route to BYPASS; otherwise the block SHALL route to ISSUE with a 4-bit counter loaded to SETTLE_CYC-1.
REQ-024 ISSUE: add_enable=1; the counter decrements each cycle; at counter 0 the next edge SHALL capture add_dst into rsp_data and go to RESP.
REQ-025 Latency, normal path: rsp_valid SHALL rise exactly SETTLE_CYC edges after the accept edge.
REQ-026 Latency, bypass path: rsp_valid SHALL rise exactly 1 edge after the accept edge.
REQ-027 BYPASS result rules, using effective signs (b sign XOR doSub after the swap):
  - any NaN operand, or inf combined with inf of opposite effective sign -> 64'h7FF8_0000_0000_0000 with flags bit2=1;
  - otherwise -> the infinity carrying its effective sign, with flags 000.
REQ-028 Normal path flags:
  - bit0=1 iff add_dst[62:0]==0;
  - bit1=1 iff add_dst[62:52]==0x7FF;
  - bit2=0.
REQ-029 RESP: rsp_valid=1; rsp_data, rsp_tag and rsp_flags SHALL stay stable while rsp_ready=0.
REQ-030 In RESP, on rsp_ready:
  - with a simultaneous new accept, go directly to ISSUE or BYPASS (back-to-back, no bubble);
  - otherwise go to IDLE.
REQ-031 add_enable SHALL be 0 in IDLE, BYPASS and RESP.
REQ-032 add_srca, add_srcb and add_doSub SHALL change only on accept.
REQ-033 req_valid outside a req_ready cycle SHALL be ignored, and input changes SHALL have no effect.

Reset
REQ-034 While reset_n=0, all state SHALL clear immediately, independent of clk:
  - state IDLE; counter 0;
  - add_srca, add_srcb, rsp_data = 0; add_doSub, add_enable, rsp_valid, busy = 0;
  - rsp_tag, rsp_flags = 0;
  - req_ready = 0 during reset, and 1 from the first edge after release.
REQ-035 Reset asserted mid-operation SHALL drop the in-flight operation with no response produced.

Verification
REQ-036 add: a=0x3FF0000000000000, b=0x4000000000000000, tag 5, SETTLE_CYC=2 -> rsp_valid 2 edges after accept, data 0x4008000000000000, tag 5, flags 000.
REQ-037 sub 3.0-3.0: a=b=0x4008000000000000 -> data 0x0000000000000000, flags 001.
REQ-038 reverse sub: a=0x3FF0000000000000, b=0x4008000000000000 -> add_srca=0x4008..., add_doSub=1, data 0x4000000000000000.
REQ-039 add +inf (0x7FF0000000000000) + -inf (0xFFF0000000000000) -> BYPASS, 1-edge latency, data 0x7FF8000000000000, flags 100, add_enable never high.
REQ-040 backpressure and reset:
  - rsp_ready low 5 cycles -> data/tag held and req_ready low;
  - then rsp_ready=1 with a new req_valid -> accepted the same cycle;
  - reset_n pulsed low mid-ISSUE -> rsp_valid/busy 0 immediately and no response emitted.
